multi_digit_converter: RTL
==========================

# multi_digit_converter

Sequential, parametrised binary-to-seven-segment converter for the alarm's distance display. It accepts a raw binary reading (e.g. the ultrasonic distance) on a start strobe and converts it to `DIGITS` BCD digits using shift-and-add-3 (double dabble), one bit per clock. It then drives one seven-segment pattern per digit, with leading-zero blanking and an explicit overflow indication. It sits between the distance measurement logic and the board's seven-segment displays. It replaces tri-stated digit outputs with defined, registered results.

## Interface
Parameters:
- `IN_WIDTH`, 7: width of the binary input.
- `DIGITS`, 2: number of displayed decimal digits.
- `LZ_BLANK`, 1: 1 blanks leading zeros; 0 shows all digits.

Ports:
- `Clock`  in  1  sole clock; all state changes on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  request conversion of `Value_Raw`, sampled on the clock edge.
- `Value_Raw`  in  `IN_WIDTH`  binary value to convert.
- `Busy`  out  1  high while a conversion is in progress.
- `Done`  out  1  one-cycle pulse when results update.
- `Overflow`  out  1  last converted value exceeded 10^DIGITS−1.
- `Digits`  out  `4*DIGITS`  BCD result; the most significant digit is in the top nibble.
- `Segments`  out  `7*DIGITS`  seven-segment patterns, 7 bits per digit in the same order as `Digits`.

## Operation
- **States:**
  - `IDLE`: waiting for a request.
  - `SHIFT`: `IN_WIDTH` double-dabble iterations.
  - `DONE`: one cycle.
- **Accepting a request:** `Start` is accepted only in `IDLE` or `DONE`.
  - On acceptance, capture `Value_Raw` into the shift register and clear the BCD accumulator.
  - Load the iteration counter with `IN_WIDTH`, set the overflow flag to (`Value_Raw` > 10^DIGITS−1), and go to `SHIFT`.
- **`Start` while in `SHIFT`:** ignored. It is neither queued nor restarted.
- **Each `SHIFT` cycle:**
  - Add 3 to every BCD nibble ≥5.
  - Shift {BCD, binary} left by one.
  - Decrement the counter.
  - On the last iteration, register `Digits`/`Overflow` and go to `DONE`.
- **`DONE` → `IDLE`:** automatic, unless `Start` is accepted, which goes straight to `SHIFT`.
- **BCD accumulator:** exactly `4*DIGITS` bits. Bits shifted out of the top nibble are discarded. This is harmless because overflowed results are replaced.
- **On overflow:** `Digits` = all nibbles 4'hF; every digit shows a dash.
- **Segment encoding:**
  - Bit 6 = a … bit 0 = g, active-low (common-anode).
  - Blank = 7'h7F.
  - Dash = 7'b1111110.
- **Leading-zero blanking** (when `LZ_BLANK` = 1): every digit above the most significant non-zero digit is blank. The units digit is never blanked, so value 0 shows "0".
- **`Segments` path:** a combinational decode of the registered `Digits`/`Overflow` and a registered "valid" flag, so it changes in the same cycle as `Digits`.
- **Reset values:**
  - State `IDLE`.
  - `Busy` 0, `Done` 0, `Overflow` 0, `Digits` 0.
  - Valid flag 0, so all `Segments` blank (all 1s) until the first conversion completes.

## Timing
- **Conversion cycle:** `Start` is sampled high at edge k.
  - `Busy` is 1 from edge k through edge k+`IN_WIDTH`.
  - At edge k+`IN_WIDTH`, `Digits`/`Overflow`/`Segments` update, `Busy` falls and `Done` rises for exactly one cycle.
- **Latency:** `IN_WIDTH` cycles from start sample to result.
- **Throughput:** one conversion per `IN_WIDTH`+1 cycles when `Start` is held high.
- **Result stability:** previous results stay stable on the outputs throughout `SHIFT`.
- **`Reset` mid-conversion:** immediate return to reset values. The partial result is discarded.
- **`Reset` and `Start` together:** reset wins.

## Structure
- **Shared package:**
  - State enum.
  - Segment constants: patterns for 0–9, blank, dash.
  - Constant function `max_decimal(DIGITS)` = 10^DIGITS−1, used for the overflow compare. Its width must be adequate for `IN_WIDTH`.
- **One sub-module:** `seg7_digit_decoder` (4-bit BCD + blank + dash in → 7-bit active-low pattern), instantiated `DIGITS` times in a generate loop.
- **FSM, counter and shift datapath:** all in the top module.

## Test plan
1. **Reset:** assert `Reset` asynchronously mid-cycle → `Busy`=0, `Done`=0, `Digits`=8'h00, `Segments`=14'h3FFF immediately; no `Done` ever appears for the aborted value.
2. **Value 42, defaults:** `Start` with `Value_Raw`=42 → `Done` 7 cycles later, `Digits`=8'h42, `Segments`={7'b1001100, 7'b0010010}, `Overflow`=0.
3. **Leading-zero blanking:**
   - `Value_Raw`=7 → `Digits`=8'h07, `Segments`={7'h7F, 7'b0001111}.
   - `Value_Raw`=0 → `Segments`={7'h7F, 7'b0000001}.
   - With `LZ_BLANK`=0, value 7 shows tens digit 7'b0000001.
4. **Overflow:**
   - `Value_Raw`=100 and 127 → `Overflow`=1, `Digits`=8'hFF, `Segments`={7'b1111110, 7'b1111110}.
   - A following conversion of 99 → `Overflow`=0, `Digits`=8'h99.
5. **Handshake:**
   - `Start` pulsed during `SHIFT` → ignored, single `Done` with the first value.
   - `Start` held high → `Done` every 8 cycles, results track `Value_Raw` at each accept.
6. **Parametrised instance:** `IN_WIDTH`=10, `DIGITS`=4, value 1023 → `Done` after 10 cycles, `Digits`=16'h1023.
   - Random sweep of all inputs against a reference model for both configurations.

Source files
------------

// File: rtl/multi_digit_converter_pkg.sv
// Shared types and constants for the binary-to-seven-segment converter.
// Segment patterns are active-low, bit 6 = a ... bit 0 = g.
package multi_digit_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Largest value representable in the given number of decimal digits.
  function automatic logic [31:0] max_decimal(input int digits);
    logic [31:0] m;
    m = 32'd1;
    for (int i = 0; i < digits; i++) m = m * 32'd10;
    return m - 32'd1;
  endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// One BCD digit to an active-low seven-segment pattern; dash overrides blank.
module seg7_digit_decoder
  import multi_digit_converter_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/multi_digit_converter.sv
// Double-dabble binary-to-BCD converter, one bit per clock, with seven-segment drive.
// States: IDLE wait for Start | SHIFT IN_WIDTH iterations | DONE one-cycle result pulse.
module multi_digit_converter
  import multi_digit_converter_pkg::*;
#(
  parameter int IN_WIDTH = 7,
  parameter int DIGITS   = 2,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [IN_WIDTH-1:0]   Value_Raw,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Overflow,
  output logic [4*DIGITS-1:0]   Digits,
  output logic [7*DIGITS-1:0]   Segments
);

  localparam int                BCD_W    = 4 * DIGITS;
  localparam int                CNT_W    = $clog2(IN_WIDTH + 1);
  localparam logic [31:0]       MAX_VAL  = max_decimal(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(IN_WIDTH);

  state_t               state, state_next;
  logic [IN_WIDTH-1:0]  bin_q;
  logic [BCD_W-1:0]     bcd_q, bcd_adj, bcd_shift;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q, valid_q;
  logic                 accept, last_iter;
  logic [DIGITS-1:0]    lz;
  logic                 zero_run;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = Start && (state == ST_IDLE || state == ST_DONE);
    last_iter  = (state == ST_SHIFT) && (cnt_q == CNT_W'(1));
    case (state)
      ST_IDLE:  if (accept) state_next = ST_SHIFT;
      ST_SHIFT: if (last_iter) state_next = ST_DONE;
      ST_DONE:  state_next = accept ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    // Carry out of the top nibble is dropped; overflowed results are replaced anyway.
    bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[IN_WIDTH-1]};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      Overflow <= 1'b0;
      Digits   <= '0;
    end else if (accept) begin
      bin_q <= Value_Raw;
      bcd_q <= '0;
      cnt_q <= CNT_LOAD;
      ovf_q <= 32'(Value_Raw) > MAX_VAL;
    end else if (state == ST_SHIFT) begin
      bin_q <= {bin_q[IN_WIDTH-2:0], 1'b0};
      bcd_q <= bcd_shift;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_iter) begin
        Digits   <= ovf_q ? {BCD_W{1'b1}} : bcd_shift;
        Overflow <= ovf_q;
        valid_q  <= 1'b1;
      end
    end
  end

  assign Busy = (state == ST_SHIFT);
  assign Done = (state == ST_DONE);

  // Blank every digit above the most significant non-zero one; units never blank.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (Digits[4*i +: 4] == 4'd0);
      lz[i]    = LZ_BLANK && zero_run;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_digit_decoder u_dec (
      .bcd   (Digits[4*g +: 4]),
      .blank (!valid_q || lz[g]),
      .dash  (valid_q && Overflow),
      .seg   (Segments[7*g +: 7])
    );
  end

endmodule
